// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared state encoding and voting helpers for the TMR fault monitor
package tmr_pkg;

    typedef enum logic [1:0] {
        ST_OK       = 2'b00,
        ST_DEGRADED = 2'b01,
        ST_FAILSAFE = 2'b10
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/consec_mismatch_counter.sv
// rtl/consec_mismatch_counter.sv - saturating consecutive-mismatch counter with sticky threshold hit
module consec_mismatch_counter #(
    parameter int CNT_W  = 4,
    parameter int THRESH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             mis,
    output logic [CNT_W-1:0] cnt,
    output logic             hit_sticky
);

    localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);

    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = '0;
        if (mis) begin
            cnt_nxt = (cnt == THR) ? cnt : cnt + CNT_W'(1);
        end
    end

    // Disabled samples leave the run untouched, so en gaps never break it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            hit_sticky <= 1'b0;
        end else if (clr) begin
            cnt        <= '0;
            hit_sticky <= 1'b0;
        end else if (en) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == THR) begin
                hit_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmr_fault_monitor.sv
// rtl/tmr_fault_monitor.sv - cross-checks a TMR voter, latches channel faults, drives a fault-aware output
module tmr_fault_monitor
    import tmr_pkg::*;
#(
    parameter int   CNT_W        = 4,
    parameter int   FAIL_THRESH  = 8,
    parameter int   VOTER_THRESH = 4,
    parameter logic SAFE_VAL     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       y,
    input  logic       clr_fault,
    output logic       y_q,
    output logic [2:0] mism,
    output logic       vote_err,
    output logic [2:0] fault_vec,
    output logic       voter_fault,
    output logic [1:0] state,
    output logic       alarm
);

    logic       m;
    logic [2:0] mism_raw;
    logic       vote_raw;
    logic [CNT_W-1:0] cnt_ch [3];
    logic [CNT_W-1:0] cnt_v;

    state_t state_q;
    state_t state_nxt;

    logic pair_x;
    logic pair_z;

    assign m        = maj3(a, b, c);
    assign mism_raw = {c != m, b != m, a != m};
    assign vote_raw = (y != m);

    for (genvar i = 0; i < 3; i++) begin : g_ch
        consec_mismatch_counter #(
            .CNT_W  (CNT_W),
            .THRESH (FAIL_THRESH)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .clr        (clr_fault),
            .mis        (mism_raw[i]),
            .cnt        (cnt_ch[i]),
            .hit_sticky (fault_vec[i])
        );
    end

    consec_mismatch_counter #(
        .CNT_W  (CNT_W),
        .THRESH (VOTER_THRESH)
    ) u_cnt_voter (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr_fault),
        .mis        (vote_raw),
        .cnt        (cnt_v),
        .hit_sticky (voter_fault)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mism     <= '0;
            vote_err <= 1'b0;
        end else if (clr_fault) begin
            mism     <= '0;
            vote_err <= 1'b0;
        end else if (en) begin
            mism     <= mism_raw;
            vote_err <= vote_raw;
        end
    end

    // Next state reads the registered fault flags, so it trails latching by one edge.
    always_comb begin
        state_nxt = ST_OK;
        if (clr_fault) begin
            state_nxt = ST_OK;
        end else if (state_q == ST_FAILSAFE) begin
            state_nxt = ST_FAILSAFE;
        end else if (voter_fault || popcount3(fault_vec) >= 2'd2) begin
            state_nxt = ST_FAILSAFE;
        end else if (popcount3(fault_vec) == 2'd1) begin
            state_nxt = ST_DEGRADED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OK;
        end else begin
            state_q <= state_nxt;
        end
    end

    // The two channels that remain trusted while exactly one is failed.
    always_comb begin
        pair_x = a;
        pair_z = b;
        case (fault_vec)
            3'b001:  begin pair_x = b; pair_z = c; end
            3'b010:  begin pair_x = a; pair_z = c; end
            default: begin pair_x = a; pair_z = b; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= 1'b0;
        end else if (clr_fault) begin
            y_q <= y_q;
        end else if (state_q == ST_FAILSAFE) begin
            y_q <= SAFE_VAL;
        end else if (en) begin
            if (state_q == ST_OK) begin
                y_q <= y;
            end else if (pair_x == pair_z) begin
                y_q <= pair_x;
            end
        end
    end

    assign state = state_q;
    assign alarm = (state_q != ST_OK);

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb/tb_tmr_fault_monitor.sv - directed self-checking bench for tmr_fault_monitor
module tb_tmr_fault_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       c = 1'b0;
    logic       y = 1'b0;
    logic       clr_fault = 1'b0;
    logic       y_q;
    logic [2:0] mism;
    logic       vote_err;
    logic [2:0] fault_vec;
    logic       voter_fault;
    logic [1:0] state;
    logic       alarm;

    int n_checks = 0;
    int n_errors = 0;

    tmr_fault_monitor #(
        .CNT_W        (4),
        .FAIL_THRESH  (8),
        .VOTER_THRESH (4),
        .SAFE_VAL     (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .a           (a),
        .b           (b),
        .c           (c),
        .y           (y),
        .clr_fault   (clr_fault),
        .y_q         (y_q),
        .mism        (mism),
        .vote_err    (vote_err),
        .fault_vec   (fault_vec),
        .voter_fault (voter_fault),
        .state       (state),
        .alarm       (alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic e, input logic ia, input logic ib, input logic ic,
                        input logic iy, input logic cl);
        en = e; a = ia; b = ib; c = ic; y = iy; clr_fault = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic yq, input logic [2:0] mm,
                             input logic ve, input logic [2:0] fv, input logic vf,
                             input logic [1:0] st);
        check({tag, ".y_q"}, {7'd0, y_q}, {7'd0, yq});
        check({tag, ".mism"}, {5'd0, mism}, {5'd0, mm});
        check({tag, ".vote_err"}, {7'd0, vote_err}, {7'd0, ve});
        check({tag, ".fault_vec"}, {5'd0, fault_vec}, {5'd0, fv});
        check({tag, ".voter_fault"}, {7'd0, voter_fault}, {7'd0, vf});
        check({tag, ".state"}, {6'd0, state}, {6'd0, st});
        check({tag, ".alarm"}, {7'd0, alarm}, {7'd0, (st != 2'b00)});
    endtask

    initial begin
        #23;
        check_all("reset", 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00);
        rst = 1'b0;
        @(posedge clk); #1;

        // all agree, y follows
        step(1, 1, 1, 1, 1, 0);
        check("agree.first_yq", {7'd0, y_q}, 8'd1);
        for (int i = 0; i < 19; i++) step(1, 1, 1, 1, 1, 0);
        check_all("agree", 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00);

        // channel c stuck low for 8 samples
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 1, 0);
        check_all("c7", 1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 2'b00);
        step(1, 1, 1, 0, 1, 0);
        check_all("c8", 1'b1, 3'b100, 1'b0, 3'b100, 1'b0, 2'b00);
        step(1, 1, 1, 0, 1, 0);
        check_all("c9", 1'b1, 3'b100, 1'b0, 3'b100, 1'b0, 2'b01);
        // survivors a,b disagree: hold
        step(1, 1, 0, 0, 0, 0);
        check_all("deg_hold", 1'b1, 3'b001, 1'b0, 3'b100, 1'b0, 2'b01);
        // survivors agree on 0 while y=1
        step(1, 0, 0, 1, 1, 0);
        check_all("deg_pair", 1'b0, 3'b100, 1'b1, 3'b100, 1'b0, 2'b01);
        step(1, 1, 1, 1, 1, 1);
        check_all("clr1", 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00);

        // broken run: 7 + match + 7
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 1, 0);
        for (int i = 0; i < 7; i++) step(1, 1, 1, 0, 1, 0);
        check_all("broken_run", 1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 2'b00);
        step(1, 1, 1, 1, 1, 0);

        // en gaps inside an 8-sample run
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0);
        check_all("gap_hold", 1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 1, 0);
        check("gap7.fault_vec", {5'd0, fault_vec}, 8'd0);
        step(1, 1, 1, 0, 1, 0);
        check("gap8.fault_vec", {5'd0, fault_vec}, 8'h04);
        step(1, 1, 1, 1, 1, 1);
        check_all("clr2", 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00);

        // voter disagrees with majority
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
        check_all("v3", 1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 2'b00);
        step(1, 0, 0, 0, 1, 0);
        check_all("v4", 1'b1, 3'b000, 1'b1, 3'b000, 1'b1, 2'b00);
        step(0, 0, 0, 0, 1, 0);
        check_all("v5", 1'b1, 3'b000, 1'b1, 3'b000, 1'b1, 2'b10);
        step(0, 1, 1, 1, 1, 0);
        check_all("safe_en0", 1'b0, 3'b000, 1'b1, 3'b000, 1'b1, 2'b10);
        step(1, 1, 1, 1, 1, 0);
        check_all("safe_abs", 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 2'b10);

        // clear beats a simultaneous enabled mismatch
        step(1, 0, 0, 1, 1, 1);
        check_all("clr3", 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00);
        step(1, 0, 0, 1, 1, 0);
        check_all("post_clr", 1'b1, 3'b100, 1'b1, 3'b000, 1'b0, 2'b00);

        // latch voter fault again, then async reset mid-cycle
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
        check("pre_rst.voter_fault", {7'd0, voter_fault}, 8'd1);
        step(1, 0, 0, 0, 1, 0);
        check("pre_rst.state", {6'd0, state}, 8'd2);
        #3 rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00);
        @(posedge clk); #2;
        rst = 1'b0;
        step(1, 1, 1, 1, 1, 0);
        check_all("after_rst", 1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tmr_fault_monitor.md
Name: tmr_fault_monitor

Overview:
- Consumes the three replicated input bits and the voted output of the 3-input majority voter stage directly upstream.
- Produces a registered, fault-aware output bit.
- Counts consecutive per-channel disagreements against an internally recomputed majority, and latches sticky channel faults.
- Cross-checks the upstream voter and escalates OK -> DEGRADED -> FAILSAFE, with an alarm for the system controller.

Parameters:
- CNT_W, 4, width of each consecutive-mismatch counter.
- FAIL_THRESH, 8, consecutive enabled mismatch samples before a channel is declared failed (1..2^CNT_W-1).
- VOTER_THRESH, 4, consecutive enabled samples where y differs from the internal majority before the voter is declared failed (1..2^CNT_W-1).
- SAFE_VAL, 0, value forced on y_q in FAILSAFE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  sample enable; when low, all state holds.
- a  in  1  replica channel 0.
- b  in  1  replica channel 1.
- c  in  1  replica channel 2.
- y  in  1  voted output of the upstream majority voter.
- clr_fault  in  1  synchronous clear of faults, counters and state.
- y_q  out  1  registered fault-aware output.
- mism  out  3  registered per-channel mismatch flags for the last enabled sample, bit0 = a.
- vote_err  out  1  registered flag: y != internal majority on the last enabled sample.
- fault_vec  out  3  sticky per-channel failed flags.
- voter_fault  out  1  sticky upstream voter failure.
- state  out  2  00 OK, 01 DEGRADED, 10 FAILSAFE.
- alarm  out  1  state != OK (combinational from state).

Behaviour:
- Reset: all outputs, counters and registers go to 0; state = OK. Reset is asynchronous and applies mid-operation.
- Internal majority: m = ab | ac | bc. Raw mismatch for channel i is ch_i != m. Raw voter error is y != m.
- Enabled edge (en=1, clr_fault=0):
  - mism and vote_err register their raw values.
  - cnt_i increments on raw mismatch, saturating at FAIL_THRESH; otherwise cnt_i goes to 0.
  - cnt_v follows the same rule for the voter against VOTER_THRESH.
- Fault latching: fault_vec[i] is set on the same edge cnt_i reaches FAIL_THRESH, and voter_fault on the edge cnt_v reaches VOTER_THRESH. Once set, both stay set until clr_fault or rst.
- State register: next state is computed from registered fault_vec/voter_fault, so it lags fault latching by one edge. State updates on every edge regardless of en.
  - FAILSAFE if popcount(fault_vec) >= 2 or voter_fault=1.
  - Else DEGRADED if popcount(fault_vec) == 1.
  - Else OK.
  - FAILSAFE is absorbing until clr_fault.
- y_q update, enabled edges only:
  - OK: y_q <= y.
  - DEGRADED: if the two non-failed channels agree, y_q <= that value; otherwise hold.
  - FAILSAFE: y_q <= SAFE_VAL on every edge, including when en=0.
- Latency: one edge from sample to y_q/mism/vote_err. A fault is visible FAIL_THRESH edges after the first mismatching sample. State follows one edge later.
- en=0: counters, mism, vote_err and y_q hold; a gap in en does not break a consecutive run.
- clr_fault=1 (priority over en): counters, fault_vec, voter_fault, mism and vote_err go to 0 and state goes to OK on that edge; y_q holds.
- Simultaneous faults: two channels reaching threshold on the same edge set both bits, and state goes directly OK -> FAILSAFE.

Decomposition:
- Shared package tmr_pkg:
  - state encoding constants ST_OK/ST_DEGRADED/ST_FAILSAFE.
  - a 3-input majority function.
  - a 3-bit popcount function.
- Sub-module consec_mismatch_counter, parameterised by CNT_W and THRESH.
  - Ports: clk, rst, en, clr, mis; outputs cnt, hit_sticky.
  - Instantiated four times: three channels plus the voter.

Test Plan:
- rst pulse mid-run with faults latched -> all outputs 0, state=00 immediately, without waiting for a clock edge.
- a=b=c=1, y=1, en=1 for 20 cycles -> y_q=1 one edge after first sample; mism=000; state=00; alarm=0.
- c=0, a=b=1, y=1 for 8 enabled cycles -> fault_vec=100 after the 8th edge, state=01 one edge later. Then a=1, b=0 -> y_q holds.
- c mismatches 7 cycles, then matches 1 cycle, then mismatches 7 cycles -> fault_vec stays 000. Separately, en=0 gaps inside an 8-sample run -> fault still latches.
- a=b=c=1, y=0 for 4 enabled cycles -> voter_fault=1, state=10, y_q=SAFE_VAL=0 even with en=0.
- From FAILSAFE, assert clr_fault together with en=1 and a mismatch -> counters, faults and mism all 0, state=00 on that edge.
